// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline registers.
package riscv_pipe_pkg;

    // Architectural zero register; never a real dependency source.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Decoded control bundle carried from ID to EX.
    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       branch;
        logic [3:0] aluOp;
    } ctrl_t;

    // Control pattern of an inserted bubble: no side effects anywhere.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // True when a source operand is actually read and names register rd.
    function automatic logic src_match(
        input logic       uses,
        input logic [4:0] src,
        input logic [4:0] rd
    );
        return uses && (src == rd);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load sitting in EX whose destination is
// read by the valid instruction currently in ID.
module load_use_detect
    import riscv_pipe_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memRead,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       hazard
);

    logic load_in_ex;
    logic src_hit;

    // Combine "real load to a non-zero register" with "ID reads that register".
    always_comb begin
        load_in_ex = ex_valid && ex_memRead && (ex_rd != REG_X0);
        src_hit    = src_match(id_uses_rs1, id_rs1, ex_rd) ||
                     src_match(id_uses_rs2, id_rs2, ex_rd);
        hazard     = load_in_ex && id_valid && src_hit;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and
// saturating stall/flush event counters.
module id_ex_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_regWrite,
    input  logic             id_memRead,
    input  logic             id_memWrite,
    input  logic             id_memToReg,
    input  logic             id_aluSrc,
    input  logic             id_branch,
    input  logic [3:0]       id_aluOp,
    input  logic             flush_ex,

    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_regWrite,
    output logic             ex_memRead,
    output logic             ex_memWrite,
    output logic             ex_memToReg,
    output logic             ex_aluSrc,
    output logic             ex_branch,
    output logic [3:0]       ex_aluOp,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;
    logic  hazard;
    logic  bubble;

    load_use_detect u_load_use_detect (
        .ex_valid    (ex_valid),
        .ex_memRead  (ex_ctrl.memRead),
        .ex_rd       (ex_rd),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .hazard      (hazard)
    );

    // Bundle ID control, derive stall/bubble and fan the EX control back out.
    always_comb begin
        id_ctrl.regWrite = id_regWrite;
        id_ctrl.memRead  = id_memRead;
        id_ctrl.memWrite = id_memWrite;
        id_ctrl.memToReg = id_memToReg;
        id_ctrl.aluSrc   = id_aluSrc;
        id_ctrl.branch   = id_branch;
        id_ctrl.aluOp    = id_aluOp;

        // A flush already discards the ID instruction, so holding PC/IF-ID
        // for it would only waste a cycle.
        stall  = hazard && !flush_ex;
        bubble = flush_ex || hazard;

        ex_regWrite = ex_ctrl.regWrite;
        ex_memRead  = ex_ctrl.memRead;
        ex_memWrite = ex_ctrl.memWrite;
        ex_memToReg = ex_ctrl.memToReg;
        ex_aluSrc   = ex_ctrl.aluSrc;
        ex_branch   = ex_ctrl.branch;
        ex_aluOp    = ex_ctrl.aluOp;
    end

    // Pipeline register: reset, then bubble on flush/hazard, else capture ID.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= REG_X0;
            ex_rs2      <= REG_X0;
            ex_rd       <= REG_X0;
            ex_ctrl     <= CTRL_BUBBLE;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl     <= id_ctrl;
        end
    end

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush_ex && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_uses_rs1, id_uses_rs2;
    logic             id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_branch;
    logic [3:0]       id_aluOp;
    logic             flush_ex;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic             ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch;
    logic [3:0]       ex_aluOp;
    logic             stall;
    logic [CNT_W-1:0] stall_count, flush_count;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc), .id_branch(id_branch),
        .id_aluOp(id_aluOp), .flush_ex(flush_ex),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_memToReg(ex_memToReg), .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch),
        .ex_aluOp(ex_aluOp), .stall(stall),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // Expected contents of the EX side of the register.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc, d1, d2, imm;
        logic [4:0]      rs1, rs2, rd;
        logic            regWrite, memRead, memWrite, memToReg, aluSrc, branch;
        logic [3:0]      aluOp;
    } ex_model_t;

    ex_model_t   m;
    int unsigned m_sc, m_fc;
    int          tests = 0;
    int          fails = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A valid load in EX to a non-zero register that ID actually reads.
    function automatic logic model_hazard();
        logic reads;
        reads = (id_uses_rs1 && id_rs1 == m.rd) || (id_uses_rs2 && id_rs2 == m.rd);
        return m.valid && m.memRead && (m.rd != 5'd0) && id_valid && reads;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic set_idle();
        reset = 1'b0; flush_ex = 1'b0;
        id_valid = 1'b0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_regWrite = 1'b0; id_memRead = 1'b0; id_memWrite = 1'b0; id_memToReg = 1'b0;
        id_aluSrc = 1'b0; id_branch = 1'b0; id_aluOp = '0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                             input logic u2, input logic [4:0] rd, input logic is_load);
        set_idle();
        id_valid = 1'b1; id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_imm = $urandom; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
        id_rd = rd; id_regWrite = 1'b1; id_memRead = is_load; id_memToReg = is_load;
        id_aluSrc = is_load; id_aluOp = is_load ? 4'd0 : 4'd1;
    endtask

    // Small index range so dependencies and x0 cases are frequent.
    task automatic set_random();
        id_valid = ($urandom_range(0, 3) != 0);
        id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
        id_regWrite = 1'($urandom); id_memRead = 1'($urandom); id_memWrite = 1'($urandom);
        id_memToReg = 1'($urandom); id_aluSrc = 1'($urandom); id_branch = 1'($urandom);
        id_aluOp = 4'($urandom);
        flush_ex = ($urandom_range(0, 7) == 0);
        reset = ($urandom_range(0, 63) == 0);
    endtask

    // One clock with the inputs currently driven: check stall, advance the
    // model across the edge, then check every registered output.
    task automatic cycle();
        logic hz, st;
        #1;
        hz = model_hazard();
        st = hz && !flush_ex;
        check_eq("stall", stall, st);
        @(posedge clk);
        if (reset) begin
            m = '0; m_sc = 0; m_fc = 0;
        end else begin
            if (st) m_sc = sat_inc(m_sc);
            if (flush_ex) m_fc = sat_inc(m_fc);
            if (flush_ex || hz) begin
                m = '0;
            end else begin
                m.valid = id_valid; m.pc = id_pc; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
                m.imm = id_imm; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
                m.regWrite = id_regWrite; m.memRead = id_memRead; m.memWrite = id_memWrite;
                m.memToReg = id_memToReg; m.aluSrc = id_aluSrc; m.branch = id_branch;
                m.aluOp = id_aluOp;
            end
        end
        @(negedge clk);
        check_eq("ex_valid", ex_valid, m.valid);
        check_eq("ex_pc", ex_pc, m.pc);
        check_eq("ex_rs1_data", ex_rs1_data, m.d1);
        check_eq("ex_rs2_data", ex_rs2_data, m.d2);
        check_eq("ex_imm", ex_imm, m.imm);
        check_eq("ex_regs", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
        check_eq("ex_ctrl", {ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch, ex_aluOp},
                 {m.regWrite, m.memRead, m.memWrite, m.memToReg, m.aluSrc, m.branch, m.aluOp});
        check_eq("stall_count", stall_count, m_sc);
        check_eq("flush_count", flush_count, m_fc);
    endtask

    task automatic do_reset();
        set_idle(); reset = 1'b1; cycle(); reset = 1'b0;
    endtask

    initial begin
        set_idle();
        m = '0; m_sc = 0; m_fc = 0;
        // Initial reset before any check, DUT state is unknown until then.
        reset = 1'b1;
        @(negedge clk);

        // Reset held with busy ID inputs.
        for (int i = 0; i < 2; i++) begin
            set_instr(5'd3, 1'b1, 5'd4, 1'b1, 5'd9, 1'b1);
            reset = 1'b1;
            cycle();
        end
        check_eq("rst_valid", ex_valid, 1'b0);
        check_eq("rst_stall", stall, 1'b0);

        // Pass-through.
        set_idle();
        id_valid = 1'b1; id_rd = 5'd5; id_rs1 = 5'd3; id_regWrite = 1'b1; id_imm = 32'h10;
        cycle();
        check_eq("pt_rd_rs1", {ex_rd, ex_rs1}, {5'd5, 5'd3});
        check_eq("pt_imm", ex_imm, 32'h10);
        check_eq("pt_valid_wr", {ex_valid, ex_regWrite}, 2'b11);

        // Load-use: one stall, one bubble, then the dependent add enters EX.
        do_reset();
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        cycle();
        set_instr(5'd2, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
        #1 check_eq("lu_stall_on", stall, 1'b1);
        cycle();
        check_eq("lu_bubble", {ex_valid, ex_rd}, {1'b0, 5'd0});
        check_eq("lu_stall_off", stall, 1'b0);
        cycle();
        check_eq("lu_add_in_ex", {ex_valid, ex_rd}, {1'b1, 5'd8});
        check_eq("lu_stall_count", stall_count, 4'd1);

        // No false stall: load to x0, and load to x7 with rs1 unused.
        do_reset();
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
        cycle();
        set_instr(5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b0);
        #1 check_eq("x0_no_stall", stall, 1'b0);
        cycle();
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        cycle();
        set_instr(5'd7, 1'b0, 5'd2, 1'b1, 5'd8, 1'b0);
        #1 check_eq("unused_no_stall", stall, 1'b0);
        cycle();
        check_eq("nofalse_count", stall_count, 4'd0);

        // Invalid ID instruction with a matching index passes as invalid.
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        cycle();
        set_instr(5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
        id_valid = 1'b0;
        cycle();
        check_eq("inval_pass", {ex_valid, ex_rd}, {1'b0, 5'd8});

        // Flush during hazard: flush wins, no stall counted.
        do_reset();
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        cycle();
        set_instr(5'd2, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
        flush_ex = 1'b1;
        #1 check_eq("fl_stall", stall, 1'b0);
        cycle();
        check_eq("fl_bubble", ex_valid, 1'b0);
        check_eq("fl_counts", {flush_count, stall_count}, {4'd1, 4'd0});

        // Saturation: 2^CNT_W + 3 separate load-use stalls.
        do_reset();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
            cycle();
            set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
            cycle();
        end
        check_eq("sat_stall_count", stall_count, 4'd15);

        // Reset asserted mid-stall.
        set_instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        cycle();
        set_instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1 check_eq("rst_mid_stall", stall, 1'b0);
        check_eq("rst_mid_counts", {stall_count, flush_count}, 8'd0);
        @(negedge clk);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            set_random();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with load-use hazard detection and branch flush.
- Captures decoded fields and register-file data from ID. Presents them to EX, including ex_rs1/ex_rs2, which the forwarding unit consumes as readReg1/readReg2.
- Stalls PC and IF/ID and inserts a bubble when a load in EX is followed by a dependent instruction in ID.
- Squashes the ID instruction when EX resolves a taken branch.

Parameters:
XLEN, 32, datapath width of PC, operands and immediate
CNT_W, 32, width of saturating stall/flush performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_uses_rs1, id_uses_rs2  in  1 each  instruction actually reads rs1/rs2
id_rs1_data, id_rs2_data, id_imm  in  XLEN each  operands, immediate
id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_branch  in  1 each  control
id_aluOp  in  4  ALU operation
flush_ex  in  1  taken branch/jump resolved in EX this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  registered copies
ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices (to forwarding unit)
ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch  out  1 each  registered control
ex_aluOp  out  4  registered ALU op
stall  out  1  combinational; holds PC and IF/ID this cycle
stall_count, flush_count  out  CNT_W each  saturating event counters

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high.
- Reset state: every ex_* output is 0, ex_valid 0, both counters 0. Reset overrides flush and hazard in the same cycle.
- Load-use hazard (combinational), asserted only when all of the following hold:
  - ex_valid, ex_memRead, and ex_rd != 0
  - id_valid
  - (id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)
- stall = hazard & ~flush_ex.
- Next-state priority at each rising edge:
  1. reset
  2. flush_ex: load bubble
  3. hazard: load bubble
  4. otherwise: capture all id_* fields; ex_valid <= id_valid
- Bubble contents:
  - ex_valid and all control bits = 0; ex_aluOp = 0.
  - ex_rs1/ex_rs2/ex_rd = 0 so the forwarding unit sees no false match.
  - Data fields = 0.
- Latency: one cycle from ID capture to EX outputs. A load-use pair costs exactly one bubble. After the bubble, ex_memRead = 0, so the hazard self-clears; a stall never exceeds one consecutive cycle.
- Flush during hazard: flush wins, stall = 0, one bubble. stall_count does not increment; flush_count does.
- Hazard only on x0 (ex_rd == 0): no stall.
- id_valid = 0 with matching indices: no stall; the invalid instruction passes with ex_valid 0.
- Counters:
  - stall_count +1 on each cycle with stall = 1.
  - flush_count +1 on each cycle with flush_ex = 1.
  - Both saturate at all-ones, no wrap.
- Reset asserted mid-stall: next cycle all outputs are at reset values and stall = 0, since ex_valid is 0.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - typedef ctrl_t: packed struct of the seven control fields, aluOp 4 bits
  - constant REG_X0 = 5'd0
  - constant CTRL_BUBBLE = '0
- Sub-module load_use_detect: the combinational hazard equation, reusable by a future dual-issue front end.

Test Plan:
1. Reset: hold reset 2 cycles with id_* nonzero -> all ex_* = 0, stall = 0, counters = 0.
2. Pass-through: id_valid = 1, id_rd = 5, id_rs1 = 3, id_regWrite = 1, id_imm = 0x10 -> next cycle ex_rd = 5, ex_rs1 = 3, ex_regWrite = 1, ex_imm = 0x10, ex_valid = 1.
3. Load-use:
   - Stimulus: lw x7 in EX (ex_memRead = 1, ex_rd = 7); ID add with id_rs2 = 7, id_uses_rs2 = 1.
   - Response: stall = 1 for exactly one cycle, then a bubble in EX (ex_valid = 0, ex_rd = 0); the add enters EX the following cycle; stall_count = 1.
4. No false stall:
   - Load to x0 with id_rs1 = 0 -> stall = 0.
   - Load to x7 with id_rs1 = 7 but id_uses_rs1 = 0 -> stall = 0.
5. Flush during hazard: same setup as scenario 3 plus flush_ex = 1 -> stall = 0, bubble next cycle, flush_count = 1, stall_count = 0.
6. Saturation: force 2^CNT_W + 3 stall cycles (CNT_W = 4 in bench) -> stall_count holds at 15.
